// File: rtl/aes_word_packer_pkg.sv
// Shared AES front-end definitions: block geometry and the packer control states.
package aes_word_packer_pkg;

   localparam int AES_BLK_W         = 128;
   localparam int AES_WORD_W        = 32;
   localparam int AES_WORDS_PER_BLK = 4;

   typedef enum logic [1:0] {
      RST    = 2'd0,
      RUN    = 2'd1,
      KEYGAP = 2'd2
   } aes_state_e;

endpackage

// File: rtl/aes_word_packer_word_assembler.sv
// Collects N_WORDS words MSB-first into a shadow register; o_done fires combinationally
// on the accepted last word, with o_vec already carrying that word in its low slot.
module word_assembler #(
   parameter int WORD_W  = 32,
   parameter int N_WORDS = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_load,
   input  logic                        i_clr,
   input  logic [WORD_W-1:0]           i_word,
   output logic                        o_done,
   output logic [N_WORDS*WORD_W-1:0]   o_vec
);

   localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

   logic [CW-1:0]               r_cnt;
   logic [N_WORDS*WORD_W-1:0]   r_shadow;
   logic                        w_take;
   logic                        w_last;

   // A clear in the same cycle swallows the incoming word, including a final one.
   assign w_take = i_load && !i_clr;
   assign w_last = (r_cnt == LAST);
   assign o_done = w_take && w_last;

   always_comb begin
      o_vec              = r_shadow;
      o_vec[WORD_W-1:0]  = i_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_shadow <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         for (int i = 0; i < N_WORDS; i++) begin
            if (r_cnt == CW'(N_WORDS - 1 - i))
               r_shadow[i*WORD_W +: WORD_W] <= i_word;
         end
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/aes_word_packer.sv
// Packs 32-bit words into AES-128 keys and plaintext blocks for a pipeline with no back-pressure.
// Handshake: a word transfers on any rising edge where in_valid && in_ready; in_ready is registered.
module aes_word_packer
   import aes_word_packer_pkg::*;
#(
   parameter int WORD_W = AES_WORD_W,
   parameter int DATA_W = AES_BLK_W,
   parameter int KEY_L  = AES_BLK_W,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_is_key,
   input  logic                sync_clr,
   output logic                data_valid_out,
   output logic [DATA_W-1:0]   plain_text,
   output logic                cipherkey_valid_out,
   output logic [KEY_L-1:0]    cipher_key,
   output logic [CNT_W-1:0]    blk_cnt,
   output logic                err_nokey,
   output aes_state_e          o_dbg_state
);

   aes_state_e          r_state;
   logic                r_in_ready;
   logic                r_data_valid;
   logic [DATA_W-1:0]   r_plain;
   logic                r_key_valid;
   logic [KEY_L-1:0]    r_key;
   logic [CNT_W-1:0]    r_blk_cnt;
   logic                r_err;

   logic                w_accept;
   logic                w_key_done;
   logic                w_data_done;
   logic [KEY_L-1:0]    w_key_vec;
   logic [DATA_W-1:0]   w_data_vec;

   assign w_accept = in_valid && r_in_ready;

   word_assembler #(.WORD_W(WORD_W), .N_WORDS(AES_WORDS_PER_BLK)) u_key_asm (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_accept && in_is_key),
      .i_clr  (sync_clr),
      .i_word (in_data),
      .o_done (w_key_done),
      .o_vec  (w_key_vec)
   );

   word_assembler #(.WORD_W(WORD_W), .N_WORDS(AES_WORDS_PER_BLK)) u_data_asm (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_accept && !in_is_key),
      .i_clr  (sync_clr),
      .i_word (in_data),
      .o_done (w_data_done),
      .o_vec  (w_data_vec)
   );

   // KEYGAP drops in_ready for one cycle so no block ever coincides with a key switch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= RST;
         r_in_ready   <= 1'b0;
         r_data_valid <= 1'b0;
         r_plain      <= '0;
         r_key_valid  <= 1'b0;
         r_key        <= '0;
         r_blk_cnt    <= '0;
         r_err        <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            RST: begin
               r_state    <= RUN;
               r_in_ready <= 1'b1;
            end
            RUN: begin
               if (w_key_done) begin
                  r_state    <= KEYGAP;
                  r_in_ready <= 1'b0;
               end
            end
            KEYGAP: begin
               r_state    <= RUN;
               r_in_ready <= 1'b1;
            end
            default: begin
               r_state    <= RST;
               r_in_ready <= 1'b0;
            end
         endcase

         if (w_key_done) begin
            r_key       <= w_key_vec;
            r_key_valid <= 1'b1;
         end

         if (w_data_done) begin
            if (r_key_valid) begin
               r_plain      <= w_data_vec;
               r_data_valid <= 1'b1;
               r_blk_cnt    <= r_blk_cnt + CNT_W'(1);
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign in_ready            = r_in_ready;
   assign data_valid_out      = r_data_valid;
   assign plain_text          = r_plain;
   assign cipherkey_valid_out = r_key_valid;
   assign cipher_key          = r_key;
   assign blk_cnt             = r_blk_cnt;
   assign err_nokey           = r_err;
   assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_aes_word_packer.sv
// Directed and random checks of aes_word_packer against a word-queue reference model.
module tb_aes_word_packer;
   import aes_word_packer_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          in_is_key = 1'b0;
   logic          sync_clr = 1'b0;
   logic          data_valid_out;
   logic [127:0]  plain_text;
   logic          cipherkey_valid_out;
   logic [127:0]  cipher_key;
   logic [31:0]   blk_cnt;
   logic          err_nokey;
   aes_state_e    dbg_state;

   always #5 clk = ~clk;

   aes_word_packer dut (
      .clk                 (clk),
      .reset               (reset),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .in_is_key           (in_is_key),
      .sync_clr            (sync_clr),
      .data_valid_out      (data_valid_out),
      .plain_text          (plain_text),
      .cipherkey_valid_out (cipherkey_valid_out),
      .cipher_key          (cipher_key),
      .blk_cnt             (blk_cnt),
      .err_nokey           (err_nokey),
      .o_dbg_state         (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int seen  = 0;

   // Reference model: pending words per path plus the observable results.
   logic [31:0]   kq[$];
   logic [31:0]   dq[$];
   logic [127:0]  m_key;
   logic [127:0]  m_pt;
   logic          m_keyv;
   logic          m_pulse;
   logic          m_err;
   logic          m_ready;
   logic [31:0]   m_cnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("in_ready",  in_ready,            m_ready);
      chk("dvalid",    data_valid_out,      m_pulse);
      chk("plain",     plain_text,          m_pt);
      chk("keyvalid",  cipherkey_valid_out, m_keyv);
      chk("key",       cipher_key,          m_key);
      chk("blk_cnt",   blk_cnt,             m_cnt);
      chk("err_nokey", err_nokey,           m_err);
   endtask

   task automatic model_reset();
      kq.delete();
      dq.delete();
      m_key   = '0;
      m_pt    = '0;
      m_keyv  = 1'b0;
      m_pulse = 1'b0;
      m_err   = 1'b0;
      m_ready = 1'b0;
      m_cnt   = '0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      sync_clr = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      check_all();
      reset = 1'b0;
   endtask

   task automatic step(input logic v, input logic k, input logic [31:0] d, input logic c,
                       output logic acc);
      logic next_ready;
      in_valid  = v;
      in_is_key = k;
      in_data   = d;
      sync_clr  = c;
      acc        = v && m_ready;
      m_pulse    = 1'b0;
      next_ready = 1'b1;
      if (c) begin
         kq.delete();
         dq.delete();
      end else if (acc) begin
         if (k) begin
            kq.push_back(d);
            if (kq.size() == 4) begin
               m_key  = {kq[0], kq[1], kq[2], kq[3]};
               m_keyv = 1'b1;
               kq.delete();
               next_ready = 1'b0;
            end
         end else begin
            dq.push_back(d);
            if (dq.size() == 4) begin
               if (m_keyv) begin
                  m_pt    = {dq[0], dq[1], dq[2], dq[3]};
                  m_pulse = 1'b1;
                  m_cnt   = m_cnt + 32'd1;
               end else begin
                  m_err = 1'b1;
               end
               dq.delete();
            end
         end
      end
      @(posedge clk);
      #1;
      m_ready = next_ready;
      check_all();
      if (data_valid_out === 1'b1) seen++;
      in_valid = 1'b0;
      sync_clr = 1'b0;
   endtask

   task automatic send(input logic k, input logic [31:0] d);
      logic a;
      a = 1'b0;
      for (int i = 0; i < 8 && !a; i++) step(1'b1, k, d, 1'b0, a);
      if (!a) begin
         total++;
         bad++;
         $error("FAIL send_timeout got=%0h exp=%0h", a, 1'b1);
      end
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, a);
   endtask

   initial begin
      logic          a;
      int            p_idx[$];
      logic [31:0]   p_cnt[$];
      logic [31:0]   fresh[4];

      // FIPS-197 C.1
      do_reset();
      send(1'b1, 32'h00010203); send(1'b1, 32'h04050607);
      send(1'b1, 32'h08090a0b); send(1'b1, 32'h0c0d0e0f);
      chk("c1_bubble", in_ready, 1'b0);
      chk("c1_key", cipher_key, 128'h000102030405060708090a0b0c0d0e0f);
      seen = 0;
      send(1'b0, 32'h00112233); send(1'b0, 32'h44556677);
      send(1'b0, 32'h8899aabb); send(1'b0, 32'hccddeeff);
      chk("c1_pt", plain_text, 128'h00112233445566778899aabbccddeeff);
      chk("c1_cnt", blk_cnt, 32'd1);
      chk("c1_pulses", seen, 1);
      idle(2);
      chk("c1_pt_hold", plain_text, 128'h00112233445566778899aabbccddeeff);

      // data without key
      do_reset();
      seen = 0;
      for (int i = 0; i < 4; i++) send(1'b0, $urandom);
      chk("nokey_err", err_nokey, 1'b1);
      idle(3);
      chk("nokey_sticky", err_nokey, 1'b1);
      chk("nokey_pulses", seen, 0);

      // data group interleaved around a key commit
      do_reset();
      send(1'b1, 32'h11111111); send(1'b1, 32'h22222222);
      send(1'b0, 32'haaaa0000); send(1'b0, 32'hbbbb1111);
      send(1'b1, 32'h33333333); send(1'b1, 32'h44444444);
      chk("ilv_bubble", in_ready, 1'b0);
      seen = 0;
      send(1'b0, 32'hcccc2222); send(1'b0, 32'hdddd3333);
      chk("ilv_key", cipher_key, 128'h11111111222222223333333344444444);
      chk("ilv_pt", plain_text, 128'haaaa0000bbbb1111cccc2222dddd3333);
      chk("ilv_pulses", seen, 1);

      // sync_clr after two words, then a fresh group
      seen = 0;
      send(1'b0, 32'hdead0001); send(1'b0, 32'hdead0002);
      step(1'b1, 1'b0, 32'hdead0003, 1'b1, a);
      for (int i = 0; i < 4; i++) begin
         fresh[i] = $urandom;
         send(1'b0, fresh[i]);
      end
      chk("clr_pulses", seen, 1);
      chk("clr_pt", plain_text, {fresh[0], fresh[1], fresh[2], fresh[3]});

      // sync_clr coinciding with the 4th word wins
      seen = 0;
      send(1'b0, 32'h1); send(1'b0, 32'h2); send(1'b0, 32'h3);
      step(1'b1, 1'b0, 32'h4, 1'b1, a);
      idle(2);
      chk("clr4_pulses", seen, 0);

      // back-to-back stream of 8 data words
      do_reset();
      for (int i = 0; i < 4; i++) send(1'b1, $urandom);
      idle(1);
      chk("b2b_cnt0", blk_cnt, 32'd0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, $urandom, 1'b0, a);
         chk("b2b_acc", a, 1'b1);
         if (data_valid_out === 1'b1) begin
            p_idx.push_back(i);
            p_cnt.push_back(blk_cnt);
         end
      end
      chk("b2b_npulse", p_idx.size(), 2);
      if (p_idx.size() == 2) begin
         chk("b2b_gap", p_idx[1] - p_idx[0], 4);
         chk("b2b_cnt1", p_cnt[0], 32'd1);
         chk("b2b_cnt2", p_cnt[1], 32'd2);
      end

      // reset mid key group
      do_reset();
      send(1'b1, 32'h01010101); send(1'b1, 32'h02020202); send(1'b1, 32'h03030303);
      do_reset();
      chk("rst_key", cipher_key, 128'h0);
      chk("rst_keyv", cipherkey_valid_out, 1'b0);
      seen = 0;
      for (int i = 0; i < 4; i++) send(1'b0, $urandom);
      chk("rst_nopulse", seen, 0);
      chk("rst_err", err_nokey, 1'b1);
      for (int i = 0; i < 4; i++) send(1'b1, $urandom);
      for (int i = 0; i < 4; i++) send(1'b0, $urandom);
      chk("rst_pulse", seen, 1);

      // random traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
                   $urandom_range(0, 24) == 0, a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_word_packer.md
# aes_word_packer

Front-end stage of the pipelined AES-128 encryptor. It accepts 32-bit words over a valid/ready bus and assembles them into 128-bit cipher keys and 128-bit plaintext blocks. It drives the cipher pipeline's `data_valid_in`, `plain_text`, `cipherkey_valid_in` and `cipher_key` inputs directly. The pipeline has no back-pressure and takes one block per cycle, so this block must present each block as a single-cycle pulse with a stable key.

## Interface
- `WORD_W`, 32: input word width.
- `DATA_W`, 128: block width; must equal `4*WORD_W`.
- `KEY_L`, 128: key width; must equal `4*WORD_W`.
- `CNT_W`, 32: width of the issued-block counter.

Ports:
- `clk` in 1: system clock; one clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: word accepted when `in_valid && in_ready`.
- `in_data` in WORD_W: input word.
- `in_is_key` in 1: 1 = word belongs to the key; 0 = word belongs to a data block.
- `sync_clr` in 1: discards both partial groups; the committed key is kept.
- `data_valid_out` out 1: one-cycle block pulse; connects to pipeline `data_valid_in`.
- `plain_text` out DATA_W: assembled block; connects to pipeline `plain_text`.
- `cipherkey_valid_out` out 1: a committed key exists; connects to `cipherkey_valid_in`.
- `cipher_key` out KEY_L: committed key; connects to `cipher_key`.
- `blk_cnt` out CNT_W: number of blocks issued; wraps modulo 2^CNT_W.
- `err_nokey` out 1: sticky flag; a data block completed before any key was committed.

## Operation
- The key path and the data path are independent assemblies, each with a 2-bit word counter (0..3) and a shadow register.
- Word order is MSB first: word 0 goes to bits [127:96], word 3 to bits [31:0]. This matches FIPS-197 byte order.
- Key path:
  - Accepted key words fill the key shadow.
  - On the 4th key word, the shadow is copied to `cipher_key` atomically, the key counter clears and `cipherkey_valid_out` is set.
  - `cipherkey_valid_out` stays set until reset.
- Data path:
  - Accepted data words fill the data shadow.
  - On the 4th data word, the data counter clears.
  - If `cipherkey_valid_out` is 1: load `plain_text` and pulse `data_valid_out`, then increment `blk_cnt`.
  - Otherwise: drop the block and set `err_nokey`.
- A partial data group survives a key commit. Key and data words may be interleaved freely.
- `sync_clr`:
  - Zeroes both word counters in that cycle.
  - A word accepted in the same cycle is discarded.
  - Has no effect on `cipher_key`, `blk_cnt` or `err_nokey`.
- `in_ready` is registered. It is low:
  - during reset;
  - in the first cycle after reset;
  - in the cycle immediately after a key commit (key-change bubble, so no block ever shares a cycle with a key switch).
  
  It is high otherwise.
- State machine:
  - `RST`: `in_ready` = 0. Go to `RUN`.
  - `RUN`: `in_ready` = 1. On key commit go to `KEYGAP`.
  - `KEYGAP`: `in_ready` = 0. Go to `RUN`.
  - `reset` forces `RST` from any state.

## Timing
- Reset values: all outputs 0, counters 0, state `RST`.
- Reset mid-group discards all partial words. Reset also clears the committed key.
- Data latency: 4th data word accepted in cycle N → `data_valid_out` = 1 and `plain_text` valid in N+1, for exactly one cycle. `plain_text` holds its value until the next issued block.
- Key latency: 4th key word accepted in cycle N → new `cipher_key` and `cipherkey_valid_out` = 1 from N+1; `in_ready` = 0 in N+1.
- Throughput: one word per cycle, so at most one block every 4 cycles. This is always within the pipeline's capacity.
- `blk_cnt` updates in the same cycle as `data_valid_out`. Wrap from all-ones to 0 is silent.
- If `sync_clr` and a 4th word arrive in the same cycle, `sync_clr` wins: no commit and no pulse.

## Structure
- Shared AES package holds:
  - `AES_BLK_W` = 128, `AES_WORD_W` = 32, `AES_WORDS_PER_BLK` = 4;
  - the state enum {`RST`, `RUN`, `KEYGAP`}.
- Sub-module `word_assembler`, parameterised on `WORD_W` and word count, instantiated twice (key and data). It holds the shadow register and counter, takes a load enable and clear, and outputs a `done` pulse with the assembled vector.

## Test plan
- FIPS-197 C.1 vector, in order:
  - Reset, then key words 00010203, 04050607, 08090a0b, 0c0d0e0f.
  - Then data words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: `cipher_key` = 000102030405060708090a0b0c0d0e0f; one `data_valid_out` pulse with `plain_text` = 00112233445566778899aabbccddeeff; `blk_cnt` = 1.
- Data block with no key committed → no `data_valid_out`; `err_nokey` = 1 and stays 1.
- Key commit → `in_ready` is 0 for exactly one cycle. A data group interleaved around the key commit still issues with the correct value.
- `sync_clr` after 2 data words, then 4 fresh data words → exactly one block, made of the fresh words.
- Back-to-back stream of 8 data words with `in_valid` held 1 → two pulses, 4 cycles apart; `blk_cnt` goes 0 → 1 → 2.
- `reset` asserted after 3 key words → all outputs 0. The next 4 key words are required before any block issues.
